uart_tx_scheduler: RTL and testbench
====================================

# uart_tx_scheduler

Round-robin scheduler that shares the single transmit path of `uart_controller` (`send_sig` / `send_data` / `busy_sending`) between `NUM_REQ` byte sources. It sits between the command-handling logic and `uart_controller`. It serialises requests and issues exactly one `send_sig` pulse per byte. Each requester gets a grant when its byte is taken and a done pulse when the UART finishes it.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, default 64: cycles to wait for `busy_sending` to rise after `send_sig`. Used only with `UART_TX_SCHED_TIMEOUT_EN`.
- `clk100mhz` in 1: the single clock; every register is on its rising edge.
- `cpu_reset` in 1: synchronous, active-high reset.
- `req` in `NUM_REQ`: level request, one bit per requester.
- `req_data` in `8*NUM_REQ`: byte for requester i on bits `[8i+7:8i]`. Must be stable while `req[i]`=1.
- `grant` out `NUM_REQ`: one-hot, one-cycle pulse when requester's byte is latched.
- `done` out `NUM_REQ`: one-hot, one-cycle pulse when that byte's transmission completes.
- `send_sig` out 1: one-cycle start strobe to `uart_controller`.
- `send_data` out 8: byte to `uart_controller`, held stable until return to IDLE.
- `busy_sending` in 1: transmitter busy flag from `uart_controller`.
- `timeout_err` out 1: one-cycle pulse when `busy_sending` never rises.
- `active` out 1: high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, WAIT_BUSY, WAIT_DONE.
- **IDLE**
  - Arbitration is enabled when `|req`=1 and `busy_sending`=0.
  - Winner is the first set `req` bit searching upward from `rr_ptr`, wrapping at `NUM_REQ-1` → 0.
  - On the next edge:
    - `grant[w]`=1 and `send_sig`=1.
    - `send_data` ← `req_data[w]`.
    - owner ← w; `rr_ptr` ← (w+1) mod `NUM_REQ`.
    - state → WAIT_BUSY.
- **WAIT_BUSY**
  - `busy_sending`=1 → WAIT_DONE.
  - With the macro enabled: after `TIMEOUT_CYCLES` cycles without busy, pulse `timeout_err`, do not pulse `done`, → IDLE.
- **WAIT_DONE**
  - `busy_sending`=0 → pulse `done[owner]`, clear `send_data` to 0, → IDLE.
- Requester protocol:
  - A requester drops `req`, or presents its next byte, in the cycle after its `grant`.
  - `req` still high after `grant` is treated as a new byte; it competes again at the next IDLE.
- `req` is ignored outside IDLE. A request arriving mid-transfer waits; nothing is lost, since `req` is a level.
- Reset values:
  - `grant`, `done`, `send_sig`, `timeout_err`, `active` = 0.
  - `send_data` = 8'h00; `rr_ptr` = 0; state = IDLE; timeout counter = 0.
- Reset mid-operation does not abort the byte already in `uart_controller`. Because IDLE holds off while `busy_sending`=1, no new start is issued until that byte drains.
- Timeout counter is `clog2(TIMEOUT_CYCLES+1)` bits, saturating, cleared on entry to WAIT_BUSY.

## Timing
- Latency from `req` to start:
  - `req` sampled high in IDLE at edge N.
  - `grant` and `send_sig` are high during cycle N+1, and `send_data` is valid in that same cycle.
- `send_sig` is exactly one cycle wide and never reasserts before `done` or `timeout_err`.
- `done` is high the cycle after `busy_sending` is sampled low in WAIT_DONE.
- Back-to-back: with `done` in cycle M, the earliest next `send_sig` is cycle M+1, provided `busy_sending` is still low.
- `busy_sending` already high in IDLE (for example after reset): no grant until it falls.
- `busy_sending` glitching low for one cycle in WAIT_DONE counts as done. `uart_controller` guarantees a clean flag.
- At most one bit of `grant` or `done` is high in any cycle, and `grant` and `done` are never high in the same cycle.

## Configuration
- Macro: `UART_TX_SCHED_TIMEOUT_EN`.
- Defined:
  - WAIT_BUSY exits after `TIMEOUT_CYCLES` cycles with a `timeout_err` pulse and returns to IDLE.
  - The pointer has already advanced, so the failed requester is not retried first.
- Undefined:
  - WAIT_BUSY waits indefinitely and the timeout counter is not built.
  - `timeout_err` is tied to 0.

## Test plan
- **Single request.** Reset, then `req`=4'b0010, `req_data[15:8]`=8'h74; the busy model rises 2 cycles after `send_sig` and holds 10 cycles.
  - Expect `grant`=4'b0010 and `send_sig`=1 one cycle after `req`, `send_data`=8'h74.
  - Expect `done`=4'b0010 one cycle after busy falls.
- **Round-robin.** `req`=4'b1111 held continuously, with bytes 8'h41..8'h44.
  - Grant order is 0,1,2,3,0; `send_data` follows as 41,42,43,44,41.
  - No two `send_sig` pulses occur without an intervening `done`.
- **Pointer wrap.** Grant requester 3 alone, then `req`=4'b1001.
  - Requester 0 wins next, then 3.
- **Busy at reset.** Hold `busy_sending`=1 through reset release, with `req`=4'b0001.
  - No `grant` until busy falls; `grant` is seen one cycle after the fall.
- **Timeout (macro defined, `TIMEOUT_CYCLES`=8).** `req`=4'b0100 with `busy_sending` stuck at 0.
  - `timeout_err` pulses 9 cycles after `send_sig`; no `done`.
  - A subsequent `req`=4'b0100 is granted again. Repeat with the macro undefined: `active` stays 1 and `timeout_err` stays 0.
- **Reset mid-operation.** Assert `cpu_reset` for 1 cycle during WAIT_DONE with busy still high.
  - All outputs are 0 the next cycle and `rr_ptr` is 0.
  - No `done` for the aborted owner; the next grant waits for busy to fall.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter that shares one uart_controller transmit path between NUM_REQ byte sources.
// Optional WAIT_BUSY timeout is built only when UART_TX_SCHED_TIMEOUT_EN is defined.
module uart_tx_scheduler #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                   clk100mhz,
    input  logic                   cpu_reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     done,
    output logic                   send_sig,
    output logic [7:0]             send_data,
    input  logic                   busy_sending,
    output logic                   timeout_err,
    output logic                   active
);

    localparam int unsigned        IDX_W   = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE_BIT = NUM_REQ'(1'b1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("uart_tx_scheduler: NUM_REQ must be 2..8 and TIMEOUT_CYCLES at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_BUSY = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [IDX_W-1:0]   rr_ptr_r, rr_ptr_s;
    logic [IDX_W-1:0]   owner_r, owner_s;
    logic [NUM_REQ-1:0] grant_r, grant_s;
    logic [NUM_REQ-1:0] done_r, done_s;
    logic               send_sig_r, send_sig_s;
    logic [7:0]         send_data_r, send_data_s;
    logic               active_r, active_s;
    logic [IDX_W:0]     pick_s;
    logic               win_found_s;
    logic [IDX_W-1:0]   win_idx_s;
    logic               timeout_hit_s;

    // First set request at or above p, wrapping; MSB of the result flags that one was found.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   p);
        logic             found;
        logic [IDX_W-1:0] w;
        int               c;
        found = 1'b0;
        w     = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            c = int'(p) + k;
            if (c >= int'(NUM_REQ)) begin
                c = c - int'(NUM_REQ);
            end else begin
                c = c;
            end
            if (!found && r[c]) begin
                found = 1'b1;
                w     = IDX_W'(c);
            end else begin
                found = found;
            end
        end
        return {found, w};
    endfunction

    assign pick_s      = rr_pick(req, rr_ptr_r);
    assign win_found_s = pick_s[IDX_W];
    assign win_idx_s   = pick_s[IDX_W-1:0];

`ifdef UART_TX_SCHED_TIMEOUT_EN
    localparam int unsigned      CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             timeout_err_r, timeout_err_s;

    assign timeout_hit_s = (cnt_r >= CNT_MAX);

    // Saturating count of WAIT_BUSY cycles; zero everywhere else so each entry starts fresh.
    always_comb begin
        cnt_s         = '0;
        timeout_err_s = 1'b0;
        if (state_r == S_WAIT_BUSY) begin
            if (cnt_r >= CNT_MAX) begin
                cnt_s = cnt_r;
            end else begin
                cnt_s = cnt_r + CNT_W'(1);
            end
            timeout_err_s = !busy_sending && timeout_hit_s;
        end else begin
            cnt_s         = '0;
            timeout_err_s = 1'b0;
        end
    end

    // Timeout counter and error strobe registers.
    always_ff @(posedge clk100mhz) begin
        if (cpu_reset) begin
            cnt_r         <= '0;
            timeout_err_r <= 1'b0;
        end else begin
            cnt_r         <= cnt_s;
            timeout_err_r <= timeout_err_s;
        end
    end

    assign timeout_err = timeout_err_r;
`else
    assign timeout_hit_s = 1'b0;
    assign timeout_err   = 1'b0;
`endif

    // Next-state and next-output decode; every output strobe defaults low.
    always_comb begin
        state_s     = state_r;
        rr_ptr_s    = rr_ptr_r;
        owner_s     = owner_r;
        grant_s     = '0;
        done_s      = '0;
        send_sig_s  = 1'b0;
        send_data_s = send_data_r;
        case (state_r)
            S_IDLE: begin
                // A byte still draining from before a reset holds off new starts.
                if (win_found_s && !busy_sending) begin
                    grant_s     = ONE_BIT << win_idx_s;
                    send_sig_s  = 1'b1;
                    send_data_s = req_data[{win_idx_s, 3'b000} +: 8];
                    owner_s     = win_idx_s;
                    if (win_idx_s == IDX_W'(NUM_REQ - 1)) begin
                        rr_ptr_s = '0;
                    end else begin
                        rr_ptr_s = win_idx_s + IDX_W'(1);
                    end
                    state_s = S_WAIT_BUSY;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_WAIT_BUSY: begin
                if (busy_sending) begin
                    state_s = S_WAIT_DONE;
                end else if (timeout_hit_s) begin
                    send_data_s = 8'h00;
                    state_s     = S_IDLE;
                end else begin
                    state_s = S_WAIT_BUSY;
                end
            end
            S_WAIT_DONE: begin
                if (!busy_sending) begin
                    done_s      = ONE_BIT << owner_r;
                    send_data_s = 8'h00;
                    state_s     = S_IDLE;
                end else begin
                    state_s = S_WAIT_DONE;
                end
            end
            default: begin
                send_data_s = 8'h00;
                state_s     = S_IDLE;
            end
        endcase
        active_s = (state_s != S_IDLE);
    end

    // State, pointer and registered outputs.
    always_ff @(posedge clk100mhz) begin
        if (cpu_reset) begin
            state_r     <= S_IDLE;
            rr_ptr_r    <= '0;
            owner_r     <= '0;
            grant_r     <= '0;
            done_r      <= '0;
            send_sig_r  <= 1'b0;
            send_data_r <= 8'h00;
            active_r    <= 1'b0;
        end else begin
            state_r     <= state_s;
            rr_ptr_r    <= rr_ptr_s;
            owner_r     <= owner_s;
            grant_r     <= grant_s;
            done_r      <= done_s;
            send_sig_r  <= send_sig_s;
            send_data_r <= send_data_s;
            active_r    <= active_s;
        end
    end

    assign grant     = grant_r;
    assign done      = done_r;
    assign send_sig  = send_sig_r;
    assign send_data = send_data_r;
    assign active    = active_r;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: transaction-level model checked every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_uart_tx_scheduler;

    localparam int N  = 4;
    localparam int TO = 8;

    logic           clk100mhz = 1'b0;
    logic           cpu_reset;
    logic [N-1:0]   req;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   grant, done;
    logic           send_sig;
    logic [7:0]     send_data;
    logic           busy_sending;
    logic           timeout_err, active;

    logic busy_auto = 1'b0, busy_man = 1'b0, auto_busy_v = 1'b0;
    int   busy_k = 100;
    int   n_cmp = 0, n_bad = 0, cyc = 0;

    always #5 clk100mhz = ~clk100mhz;
    assign busy_sending = busy_auto ? auto_busy_v : busy_man;

    uart_tx_scheduler #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk100mhz(clk100mhz), .cpu_reset(cpu_reset), .req(req), .req_data(req_data),
        .grant(grant), .done(done), .send_sig(send_sig), .send_data(send_data),
        .busy_sending(busy_sending), .timeout_err(timeout_err), .active(active)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // UART busy responder: busy rises 2 cycles after send_sig and stays high for 10 cycles.
    always @(negedge clk100mhz) begin
        if (send_sig === 1'b1) busy_k = 0;
        else if (busy_k < 1000) busy_k = busy_k + 1;
        auto_busy_v = (busy_k >= 2) && (busy_k < 12);
    end

    // Transaction model: one outstanding byte at a time, round-robin pick, done when busy is seen to fall.
    bit   m_live = 0, m_xfer = 0, m_seen = 0;
    int   m_ptr = 0, m_owner = 0, m_wait = 0, w;
    logic [N-1:0] e_grant = '0, e_done = '0;
    logic e_send = 1'b0, e_to = 1'b0, e_active = 1'b0;
    logic [7:0] e_data = 8'h00;

    always @(posedge clk100mhz) begin
        cyc = cyc + 1;
        e_grant = '0; e_done = '0; e_send = 1'b0; e_to = 1'b0;
        if (cpu_reset === 1'b1) begin
            m_live = 1; m_xfer = 0; m_ptr = 0; e_data = 8'h00;
        end else if (!m_xfer) begin
            if (req != '0 && busy_sending == 1'b0) begin
                w = -1;
                for (int k = 0; k < N; k++)
                    if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                e_grant[w] = 1'b1; e_send = 1'b1; e_data = req_data[8*w +: 8];
                m_owner = w; m_ptr = (w + 1) % N; m_xfer = 1; m_seen = 0; m_wait = 0;
            end
        end else if (!m_seen) begin
            if (busy_sending) m_seen = 1;
`ifdef UART_TX_SCHED_TIMEOUT_EN
            else if (m_wait == TO) begin m_xfer = 0; e_to = 1'b1; e_data = 8'h00; end
`endif
            else m_wait = m_wait + 1;
        end else if (!busy_sending) begin
            e_done[m_owner] = 1'b1; e_data = 8'h00; m_xfer = 0;
        end
        e_active = m_xfer;
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk100mhz) begin
        if (m_live) begin
            check("grant", grant, e_grant);
            check("done", done, e_done);
            check("send_sig", send_sig, e_send);
            check("send_data", send_data, e_data);
            check("timeout_err", timeout_err, e_to);
            check("active", active, e_active);
        end
    end

    // Event recorder used by the directed checks.
    int g_idx_q[$], g_cyc_q[$];
    logic [7:0] g_data_q[$];
    int s_cyc = 0, d_cyc = 0, t_cyc = 0, d_cnt = 0, t_cnt = 0, viol = 0;
    logic [N-1:0] d_val = '0;
    bit pending = 0;
    always @(negedge clk100mhz) begin
        for (int i = 0; i < N; i++)
            if (grant[i] === 1'b1) begin
                g_idx_q.push_back(i); g_data_q.push_back(send_data); g_cyc_q.push_back(cyc);
            end
        if (done != '0) begin d_cyc = cyc; d_val = done; d_cnt++; pending = 0; end
        if (timeout_err === 1'b1) begin t_cyc = cyc; t_cnt++; pending = 0; end
        if (cpu_reset === 1'b1) pending = 0;
        if (send_sig === 1'b1) begin
            if (pending) viol++;
            pending = 1; s_cyc = cyc;
        end
    end

    function automatic int gi(input int i);
        return (i < g_idx_q.size()) ? g_idx_q[i] : -1;
    endfunction
    function automatic int gc(input int i);
        return (i < g_cyc_q.size()) ? g_cyc_q[i] : -1;
    endfunction
    function automatic int gd(input int i);
        return (i < g_data_q.size()) ? int'(g_data_q[i]) : -1;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin @(negedge clk100mhz); #1; end
    endtask
    task automatic clear_q();
        g_idx_q.delete(); g_cyc_q.delete(); g_data_q.delete();
    endtask
    task automatic do_reset();
        tick(1); cpu_reset = 1'b1; tick(1); cpu_reset = 1'b0; clear_q();
    endtask
    task automatic wait_grants(input int cnt, input string name);
        int budget = 300;
        while (g_idx_q.size() < cnt && budget > 0) begin tick(1); budget--; end
        if (g_idx_q.size() < cnt) begin
            n_cmp++; n_bad++; $display("FAIL %s: grant count %0d, required %0d", name, g_idx_q.size(), cnt);
        end
    endtask
    task automatic wait_done(input int target, input string name);
        int budget = 300;
        while (d_cnt < target && budget > 0) begin tick(1); budget--; end
        if (d_cnt < target) begin
            n_cmp++; n_bad++; $display("FAIL %s: done count %0d, required %0d", name, d_cnt, target);
        end
    endtask

    int r_cyc, f_cyc, s0, d0, guard;
    int exp_ord[5] = '{0, 1, 2, 3, 0};
    int exp_dat[5] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h41};

    initial begin
        cpu_reset = 1'b1; req = '0; req_data = '0;
        tick(3);
        cpu_reset = 1'b0;
        check("rst_grant", grant, 0); check("rst_done", done, 0); check("rst_send", send_sig, 0);
        check("rst_data", send_data, 8'h00); check("rst_active", active, 0); check("rst_to", timeout_err, 0);

        // Single request
        busy_auto = 1'b1; clear_q(); d0 = d_cnt;
        req_data[15:8] = 8'h74; req = 4'b0010; r_cyc = cyc;
        wait_grants(1, "single_grant"); req = '0;
        check("single_idx", gi(0), 1); check("single_data", gd(0), 8'h74);
        check("single_latency", gc(0) - r_cyc, 1);
        wait_done(d0 + 1, "single_done");
        check("single_done_vec", d_val, 4'b0010); check("single_done_latency", d_cyc - s_cyc, 13);

        // Round-robin with all four requesting
        do_reset(); d0 = d_cnt; viol = 0;
        req_data = {8'h44, 8'h43, 8'h42, 8'h41}; req = 4'b1111;
        wait_grants(5, "rr_grants"); req = '0;
        for (int i = 0; i < 5; i++) begin
            check("rr_order", gi(i), exp_ord[i]); check("rr_data", gd(i), exp_dat[i]);
        end
        wait_done(d0 + 5, "rr_done");
        check("rr_send_without_done", viol, 0);

        // Pointer wrap 3 -> 0
        do_reset(); d0 = d_cnt;
        req = 4'b1000; wait_grants(1, "wrap_first"); req = '0;
        wait_done(d0 + 1, "wrap_first_done");
        req = 4'b1001; wait_grants(3, "wrap_pair"); req = '0;
        check("wrap_first_idx", gi(0), 3); check("wrap_next0", gi(1), 0); check("wrap_next3", gi(2), 3);
        wait_done(d0 + 3, "wrap_done");

        // Busy already high across reset release
        tick(1); cpu_reset = 1'b1; busy_auto = 1'b0; busy_man = 1'b1; req = 4'b0001;
        tick(2); cpu_reset = 1'b0; clear_q(); d0 = d_cnt;
        tick(6);
        check("busy_rst_no_grant", g_idx_q.size(), 0);
        busy_man = 1'b0; busy_auto = 1'b1; f_cyc = cyc;
        wait_grants(1, "busy_rst_grant"); req = '0;
        check("busy_rst_idx", gi(0), 0); check("busy_rst_latency", gc(0) - f_cyc, 1);
        wait_done(d0 + 1, "busy_rst_done");

        // WAIT_BUSY with busy stuck low
        do_reset(); busy_auto = 1'b0; busy_man = 1'b0; d0 = d_cnt;
        req = 4'b0100; wait_grants(1, "to_grant"); req = '0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
        guard = 0;
        while (t_cnt < 1 && guard < 100) begin tick(1); guard++; end
        check("to_seen", t_cnt, 1); check("to_latency", t_cyc - s_cyc, 9); check("to_no_done", d_cnt, d0);
        req = 4'b0100; wait_grants(2, "to_regrant"); req = '0;
        check("to_regrant_idx", gi(1), 2);
        guard = 0;
        while (t_cnt < 2 && guard < 100) begin tick(1); guard++; end
        check("to_second", t_cnt, 2); check("to_no_done2", d_cnt, d0);
`else
        tick(20);
        check("nto_active", active, 1); check("nto_err", t_cnt, 0); check("nto_no_done", d_cnt, d0);
        busy_man = 1'b1; tick(2); busy_man = 1'b0;
        wait_done(d0 + 1, "nto_done");
        check("nto_done_vec", d_val, 4'b0100);
`endif

        // Reset in WAIT_DONE while the UART is still busy
        do_reset(); busy_auto = 1'b1; d0 = d_cnt;
        req = 4'b0001; wait_grants(1, "mid_grant"); req = '0; s0 = s_cyc;
        guard = 0;
        while (cyc < s0 + 5 && guard < 50) begin tick(1); guard++; end
        cpu_reset = 1'b1; tick(1); cpu_reset = 1'b0; clear_q();
        check("mid_grant0", grant, 0); check("mid_done0", done, 0); check("mid_send0", send_sig, 0);
        check("mid_data0", send_data, 8'h00); check("mid_active0", active, 0);
        req = 4'b0011;
        wait_grants(1, "mid_regrant"); req = '0;
        check("mid_ptr_reset", gi(0), 0); check("mid_wait_drain", gc(0) - s0, 13);
        check("mid_no_done", d_cnt, d0);
        wait_done(d0 + 1, "mid_done");
        check("mid_done_vec", d_val, 4'b0001);

        tick(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
